pipelined_ripple_adder: RTL
===========================

Name: pipelined_ripple_adder

Overview:
Parametrised, pipelined signed/unsigned adder-subtractor, the successor to the single-cycle ripple-carry adder.
- Operand width is split into STAGES equal ripple-carry chunks; the carry is registered between chunks.
- Operands and results move through a valid/ready handshake, so the block sits directly in streaming datapaths (accumulators, MAC back-ends).
- Adds a subtract mode, back-pressure and signed-overflow reporting per result.

Parameters:
WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
STAGES, 4, pipeline depth and chunk count; chunk width CW = WIDTH/STAGES; legal range 1..WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  a, b, cin, sub are valid this cycle
in_ready  output  1  block accepts the input this cycle
a  input  WIDTH  operand A (two's complement when read as signed)
b  input  WIDTH  operand B
cin  input  1  carry-in; used only when sub=0
sub  input  1  1: result = a - b; 0: result = a + b + cin
out_valid  output  1  sum, cout, overflow valid
out_ready  input  1  downstream accepts the result
sum  output  WIDTH  result
cout  output  1  carry out of bit WIDTH-1 (sub: 1 = no borrow)
overflow  output  1  signed overflow of this result

Behaviour:
- Reset: all stage valid bits = 0; out_valid = 0; sum = 0; cout = 0; overflow = 0; in-flight operations are discarded. rst dominates in_valid on the same edge.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv, combinational; no combinational path from in_valid to in_ready.
- Transfers:
  - Accept when in_valid && in_ready.
  - Result leaves when out_valid && out_ready.
  - When adv = 0, every stage register holds, including valid bits and skewed operands.
- Operand prep at accept: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (k = 0..STAGES-1):
  - Adds chunk k of a and b_eff, bits [k*CW +: CW], plus the carry registered from stage k-1 (c0 for stage 0).
  - Registers the chunk sum and carry-out.
  - Unprocessed upper chunks and the already-produced lower sum chunks travel in skew registers alongside.
- Latency: exactly STAGES cycles from accept to out_valid with no stalls. Throughput: 1 result per cycle.
- Final stage:
  - cout = carry out of bit WIDTH-1.
  - overflow = carry into MSB XOR carry out of MSB, equivalently (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
  - Both are registered with sum and valid in the same cycle.
- Arithmetic: sum wraps modulo 2^WIDTH. Results emerge in acceptance order and are never dropped or duplicated.
- Stall boundary: with out_valid=1 and out_ready=0, sum/cout/overflow/out_valid stay stable until the transfer. in_ready=0; any offered input is not accepted.
- Simultaneous accept and output transfer in one cycle is legal (full-rate streaming).
- Bubbles: in_valid=0 while adv=1 inserts an invalid slot; out_valid follows the bubble STAGES cycles later.
- STAGES=1: one full-width ripple add registered once; latency 1.
- Reset mid-operation: next cycle out_valid=0 and all pipeline valids are 0; the first post-reset accept emerges STAGES cycles later.

Optional Feature:
SATURATE_EN
- Defined:
  - On signed overflow, sum is clamped: positive overflow (a[MSB]=0) gives 2^(WIDTH-1)-1; negative overflow gives -2^(WIDTH-1).
  - overflow is still asserted; cout is unchanged (raw carry).
  - Clamp is applied in the final stage; latency is unchanged.
- Undefined: wrap-around result; no clamp logic synthesised.

Test Plan:
- Reset then single add, WIDTH=32, STAGES=4: a=2147483647, b=1, sub=0, cin=0 -> after exactly 4 cycles out_valid=1, sum=-2147483648, overflow=1, cout=0 (SATURATE_EN: sum=2147483647, overflow=1).
- Subtract: a=100, b=50, sub=1 -> sum=50, overflow=0, cout=1. Then a=-2147483648, b=1, sub=1 -> sum=2147483647, overflow=1 (SATURATE_EN: sum=-2147483648).
- Streaming with cross-chunk carry:
  - Back-to-back inputs (200+150, -100+-200, -50+50, 0xFFFFFFFF+1) with out_ready=1 -> results 350, -300, 0, 0 on 4 consecutive cycles.
  - The last result: cout=1, overflow=0; its carry ripples across all 4 chunks.
- Back-pressure: hold out_ready=0 for 5 cycles while results are in flight -> in_ready=0, sum held stable, no result lost. Release -> remaining results drain in order, one per cycle.
- Reset mid-flight: accept 3 operations, assert rst for 1 cycle -> out_valid=0 next cycle and none of the 3 results ever appear. Then 50+75 -> 125 after 4 cycles.
- STAGES=1 build: a=-100, b=100, cin=1 -> next cycle sum=1, cout=1, overflow=0.

Source files
------------

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: STAGES chunks of WIDTH/STAGES bits, carry registered between chunks.
// Optional SATURATE_EN clamps the final sum on signed overflow (cout still reports the raw carry).
module pipelined_ripple_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW  = WIDTH / STAGES;
    localparam int MSB = WIDTH - 1;

    logic adv;

    // Element k holds the inputs seen by stage k (element 0 comes straight from the ports).
    logic             v_in [STAGES];
    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];
    logic             c_in [STAGES];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign v_in[0] = in_valid;
    assign a_in[0] = a;
    assign b_in[0] = sub ? ~b : b;
    assign c_in[0] = sub ? 1'b1 : cin;
    assign s_in[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CW;

        logic [CW:0]      chunk;
        logic [WIDTH-1:0] s_nxt;

        assign chunk = {1'b0, a_in[k][LO +: CW]} + {1'b0, b_in[k][LO +: CW]}
                     + {{CW{1'b0}}, c_in[k]};

        always_comb begin
            s_nxt           = s_in[k];
            s_nxt[LO +: CW] = chunk[CW-1:0];
        end

        if (k < STAGES - 1) begin : g_mid
            logic             v_r;
            logic [WIDTH-1:0] a_r;
            logic [WIDTH-1:0] b_r;
            logic [WIDTH-1:0] s_r;
            logic             c_r;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_r <= 1'b0;
                    a_r <= '0;
                    b_r <= '0;
                    s_r <= '0;
                    c_r <= 1'b0;
                end else if (adv) begin
                    v_r <= v_in[k];
                    a_r <= a_in[k];
                    b_r <= b_in[k];
                    s_r <= s_nxt;
                    c_r <= chunk[CW];
                end
            end

            assign v_in[k+1] = v_r;
            assign a_in[k+1] = a_r;
            assign b_in[k+1] = b_r;
            assign s_in[k+1] = s_r;
            assign c_in[k+1] = c_r;
        end else begin : g_last
            logic             ovf_nxt;
            logic [WIDTH-1:0] sum_nxt;

            // Operands of equal sign producing a result of the other sign.
            assign ovf_nxt = (a_in[k][MSB] == b_in[k][MSB]) && (s_nxt[MSB] != a_in[k][MSB]);

`ifdef SATURATE_EN
            logic [WIDTH-1:0] sat_max;
            assign sat_max = {WIDTH{1'b1}} >> 1;
            assign sum_nxt = !ovf_nxt     ? s_nxt   :
                             a_in[k][MSB] ? ~sat_max : sat_max;
`else
            assign sum_nxt = s_nxt;
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    cout      <= 1'b0;
                    overflow  <= 1'b0;
                end else if (adv) begin
                    out_valid <= v_in[k];
                    sum       <= sum_nxt;
                    cout      <= chunk[CW];
                    overflow  <= ovf_nxt;
                end
            end
        end
    end

endmodule
